// File: rtl/reg_file_param.sv
// reg_file_param
//   Parameterised two-read / one-write register file with a per-register
//   pending scoreboard. After reset an internal sequence clears every
//   register (one per cycle) before normal operation begins.
//
// Parameters
//   XLEN     data width in bits
//   DEPTH    number of registers (power of two, >= 2)
//   ZERO_REG when 1, index 0 reads as zero, ignores writes, never pends
//
// Ports
//   clk                 clock, rising edge
//   reset               synchronous, active-high reset
//   we, waddr, wdata    write port; a write also clears pending[waddr]
//   re                  read request for both read ports
//   raddr1, raddr2      read indices
//   alloc, alloc_addr   mark a register pending (alloc wins over a write)
//   rdata1, rdata2      registered read data, 1-cycle latency
//   pend1, pend2        registered pending status of the read indices
//   rvalid              1-cycle pulse when read outputs were updated
//   init_busy           high while the clear sequence runs
module reg_file_param #(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  input  logic [$clog2(DEPTH)-1:0] raddr2,
  input  logic                     alloc,
  input  logic [$clog2(DEPTH)-1:0] alloc_addr,
  output logic [XLEN-1:0]          rdata1,
  output logic [XLEN-1:0]          rdata2,
  output logic                     rvalid,
  output logic                     pend1,
  output logic                     pend2,
  output logic                     init_busy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]      state;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pendBits;
  logic [DEPTH-1:0] pendNext;

  logic            running;
  logic            wrEn;
  logic            allocEn;
  logic            rdEn;
  logic [XLEN-1:0] rdNext1;
  logic [XLEN-1:0] rdNext2;

  // True for the hard-wired zero register.
  function automatic logic isZeroIdx(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Read mux with write-first bypass; the zero register always wins.
  function automatic logic [XLEN-1:0] readPort(input logic [AW-1:0] ra,
                                               input logic          wr,
                                               input logic [AW-1:0] wa,
                                               input logic [XLEN-1:0] wd,
                                               input logic [XLEN-1:0] stored);
    if (isZeroIdx(ra))
      return '0;
    else if (wr && (wa == ra))
      return wd;
    else
      return stored;
  endfunction

  assign running   = (state == RUN);
  assign init_busy = (state == INIT);
  assign wrEn      = running && we && !isZeroIdx(waddr);
  assign allocEn   = running && alloc && !isZeroIdx(alloc_addr);
  assign rdEn      = running && re;

  // Scoreboard next state: clear on write first, then set on alloc so that
  // a same-index alloc and write leave the bit set.
  always_comb begin
    pendNext = pendBits;
    if (wrEn)
      pendNext[waddr] = 1'b0;
    if (allocEn)
      pendNext[alloc_addr] = 1'b1;
    if (ZERO_REG != 0)
      pendNext[0] = 1'b0;
  end

  always_comb begin
    rdNext1 = readPort(raddr1, wrEn, waddr, wdata, regs[raddr1]);
    rdNext2 = readPort(raddr2, wrEn, waddr, wdata, regs[raddr2]);
  end

  // Control: clear sequence and scoreboard.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      idx      <= '0;
      pendBits <= '0;
    end else begin
      pendBits <= pendNext;
      if (state == INIT) begin
        idx <= idx + AW'(1);
        if (idx == AW'(DEPTH - 1))
          state <= RUN;
      end
    end
  end

  // Storage array: cleared by the INIT sequence rather than by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT)
        regs[idx] <= '0;
      else if (wrEn)
        regs[waddr] <= wdata;
    end
  end

  // Read output stage (1-cycle latency); holds when no read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata1 <= '0;
      rdata2 <= '0;
      pend1  <= 1'b0;
      pend2  <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rdEn;
      if (rdEn) begin
        rdata1 <= rdNext1;
        rdata2 <= rdNext2;
        pend1  <= pendNext[raddr1];
        pend2  <= pendNext[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed testbench for reg_file_param (XLEN=64, DEPTH=32, ZERO_REG=1).
module tb_reg_file_param;

  localparam int XLEN  = 64;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic            clk;
  logic            reset;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic            re;
  logic [AW-1:0]   raddr1;
  logic [AW-1:0]   raddr2;
  logic            alloc;
  logic [AW-1:0]   alloc_addr;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            rvalid;
  logic            pend1;
  logic            pend2;
  logic            init_busy;

  int nCompared;
  int nMismatched;

  reg_file_param #(.XLEN(XLEN), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr1(raddr1), .raddr2(raddr2), .alloc(alloc),
    .alloc_addr(alloc_addr), .rdata1(rdata1), .rdata2(rdata2),
    .rvalid(rvalid), .pend1(pend1), .pend2(pend2), .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; re = 0; alloc = 0;
    waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0; alloc_addr = '0;
  endtask

  // Counts cycles init_busy stays high, bounded.
  task automatic countInit(output int cnt, output logic sawValid);
    cnt = 0;
    sawValid = 1'b0;
    while (init_busy && cnt < 100) begin
      tick();
      if (rvalid) sawValid = 1'b1;
      cnt++;
    end
  endtask

  int   cnt;
  logic sawValid;

  initial begin
    nCompared = 0;
    nMismatched = 0;
    idle();
    reset = 1;
    tick();
    reset = 0;

    // Reset state
    checkVal("rst_init_busy", 64'(init_busy), 64'd1);
    checkVal("rst_rvalid", 64'(rvalid), 64'd0);
    checkVal("rst_rdata1", rdata1, 64'd0);
    checkVal("rst_pend1", 64'(pend1), 64'd0);

    // INIT ignores we/re/alloc
    we = 1; waddr = 5'd3; wdata = 64'hFF;
    re = 1; raddr1 = 5'd3;
    alloc = 1; alloc_addr = 5'd3;
    countInit(cnt, sawValid);
    idle();
    checkVal("init_len", 64'(cnt), 64'd32);
    checkVal("init_no_rvalid", 64'(sawValid), 64'd0);

    // First read after init: cleared registers, no pending from INIT alloc
    re = 1; raddr1 = 5'd5; raddr2 = 5'd3;
    tick();
    checkVal("rd5_rvalid", 64'(rvalid), 64'd1);
    checkVal("rd5_rdata1", rdata1, 64'd0);
    checkVal("rd3_rdata2", rdata2, 64'd0);
    checkVal("rd3_pend2", 64'(pend2), 64'd0);
    re = 0;
    tick();
    checkVal("noread_rvalid", 64'(rvalid), 64'd0);

    // Write reg 7, read on both ports
    we = 1; waddr = 5'd7; wdata = 64'hDEADBEEF;
    tick();
    idle();
    re = 1; raddr1 = 5'd7; raddr2 = 5'd7;
    tick();
    checkVal("r7_rdata1", rdata1, 64'hDEADBEEF);
    checkVal("r7_rdata2", rdata2, 64'hDEADBEEF);
    checkVal("r7_pend1", 64'(pend1), 64'd0);
    checkVal("r7_pend2", 64'(pend2), 64'd0);
    checkVal("r7_rvalid", 64'(rvalid), 64'd1);

    // re=0 holds outputs
    idle();
    raddr1 = 5'd5;
    tick();
    checkVal("hold_rdata1", rdata1, 64'hDEADBEEF);
    checkVal("hold_rvalid", 64'(rvalid), 64'd0);

    // Write-to-read bypass
    we = 1; waddr = 5'd9; wdata = 64'h55;
    re = 1; raddr1 = 5'd7; raddr2 = 5'd9;
    tick();
    idle();
    checkVal("bypass_rdata2", rdata2, 64'h55);
    checkVal("bypass_rdata1", rdata1, 64'hDEADBEEF);

    // Zero register: write dropped, bypass suppressed, never pending
    we = 1; waddr = 5'd0; wdata = 64'h1234;
    tick();
    idle();
    re = 1; raddr1 = 5'd0; raddr2 = 5'd9;
    tick();
    checkVal("z_rdata1", rdata1, 64'd0);
    checkVal("z_rdata2_r9", rdata2, 64'h55);
    we = 1; waddr = 5'd0; wdata = 64'h1234;
    re = 1; raddr1 = 5'd0;
    alloc = 1; alloc_addr = 5'd0;
    tick();
    idle();
    checkVal("z_bypass_rdata1", rdata1, 64'd0);
    checkVal("z_alloc_pend1", 64'(pend1), 64'd0);
    re = 1; raddr1 = 5'd0;
    tick();
    idle();
    checkVal("z_pend1_later", 64'(pend1), 64'd0);

    // Pending scoreboard on reg 12
    alloc = 1; alloc_addr = 5'd12;
    tick();
    idle();
    re = 1; raddr1 = 5'd12; raddr2 = 5'd7;
    tick();
    idle();
    checkVal("p12_pend1", 64'(pend1), 64'd1);
    checkVal("p12_pend2_r7", 64'(pend2), 64'd0);
    we = 1; waddr = 5'd12; wdata = 64'hAA;
    alloc = 1; alloc_addr = 5'd12;
    re = 1; raddr1 = 5'd12; raddr2 = 5'd12;
    tick();
    idle();
    checkVal("p12_allocwins_pend1", 64'(pend1), 64'd1);
    checkVal("p12_allocwins_pend2", 64'(pend2), 64'd1);
    checkVal("p12_bypass_rdata1", rdata1, 64'hAA);
    we = 1; waddr = 5'd12; wdata = 64'hBB;
    tick();
    idle();
    re = 1; raddr1 = 5'd12;
    tick();
    idle();
    checkVal("p12_cleared_pend1", 64'(pend1), 64'd0);
    checkVal("p12_rdata1", rdata1, 64'hBB);

    // Pending on port 2 only, and same-edge visibility of alloc
    alloc = 1; alloc_addr = 5'd20;
    re = 1; raddr1 = 5'd7; raddr2 = 5'd20;
    tick();
    idle();
    checkVal("p20_pend2", 64'(pend2), 64'd1);
    checkVal("p20_pend1_r7", 64'(pend1), 64'd0);

    // Reset during a read
    re = 1; raddr1 = 5'd7; raddr2 = 5'd12;
    reset = 1;
    tick();
    reset = 0;
    idle();
    checkVal("rstrd_rvalid", 64'(rvalid), 64'd0);
    checkVal("rstrd_rdata1", rdata1, 64'd0);
    checkVal("rstrd_init_busy", 64'(init_busy), 64'd1);

    // Reset again at INIT cycle 10: full sequence restarts
    for (int i = 0; i < 10; i++) tick();
    reset = 1;
    tick();
    reset = 0;
    countInit(cnt, sawValid);
    checkVal("reinit_len", 64'(cnt), 64'd32);

    // Registers cleared and scoreboard empty after re-init
    re = 1; raddr1 = 5'd7; raddr2 = 5'd20;
    tick();
    idle();
    checkVal("post_rdata1", rdata1, 64'd0);
    checkVal("post_pend2", 64'(pend2), 64'd0);
    checkVal("post_rvalid", 64'(rvalid), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
